// File: rtl/huc6280_pkg.sv
// Shared definitions for the HuC6280 CPU-side bus initiator.
//   - bus_state_t : initiator FSM states
//   - chip_sel_t  : which chip select a physical bank decodes to
//   - mpr_t       : 8-bit MPR bank value
//   - paddr_t     : 21-bit physical address
//   - bank constants and the bank decode helper
package huc6280_pkg;

    typedef logic [7:0]  mpr_t;
    typedef logic [20:0] paddr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_CAPTURE
    } bus_state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ROM,
        SEL_RAM,
        SEL_IO
    } chip_sel_t;

    localparam mpr_t RAM_BANK_LO = 8'hF8;
    localparam mpr_t RAM_BANK_HI = 8'hFB;
    localparam mpr_t IO_BANK     = 8'hFF;
    localparam mpr_t OPEN_BUS    = 8'hFF;

    // Banks $00..RAM_BANK_LO-1 are HuCard ROM, RAM_BANK_LO..RAM_BANK_HI are
    // work RAM, IO_BANK is the hardware page; anything else is open bus.
    function automatic chip_sel_t decode_bank(input mpr_t b);
        chip_sel_t sel;
        if (b >= RAM_BANK_LO && b <= RAM_BANK_HI) begin
            sel = SEL_RAM;
        end else if (b == IO_BANK) begin
            sel = SEL_IO;
        end else if (b < RAM_BANK_LO) begin
            sel = SEL_ROM;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/huc6280_bus_if_if.sv
// Physical-bus interface between the HuC6280 initiator and the memory/IO
// responder.
//   addr     : 21-bit physical address (initiator -> responder)
//   mem_dout : write data            (initiator -> responder)
//   mem_din  : registered read data  (responder -> initiator)
//   re / we  : read / write strobes  (initiator -> responder)
//   CE_n / CER_n / CE7_n : ROM, work RAM, IO page selects, active low
interface huc6280_bus_if_if;
    import huc6280_pkg::*;

    paddr_t      addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        re;
    logic        we;
    logic        CE_n;
    logic        CER_n;
    logic        CE7_n;

    modport master (
        output addr, mem_dout, re, we, CE_n, CER_n, CE7_n,
        input  mem_din
    );

    modport slave (
        input  addr, mem_dout, re, we, CE_n, CER_n, CE7_n,
        output mem_din
    );
endinterface

// File: rtl/huc6280_mpr_file.sv
// Eight MPR bank registers with TAM/TMA access and logical->physical
// translation.
//   clk, rst   : clock, asynchronous active-high reset (all MPRs -> $00)
//   mpr_we     : TAM strobe, writes mpr_wdata into every MPRn with mpr_sel[n]
//   mpr_sel    : MPR select mask
//   mpr_wdata  : TAM data
//   mpr_rdata  : TMA result, MPR of the lowest set mask bit ($00 for mask 0)
//   laddr      : logical address to translate
//   paddr      : {MPR[laddr[15:13]], laddr[12:0]}, combinational from the
//                current (pre-write) register contents
module huc6280_mpr_file
    import huc6280_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mpr_we,
    input  logic [7:0]  mpr_sel,
    input  mpr_t        mpr_wdata,
    output mpr_t        mpr_rdata,
    input  logic [15:0] laddr,
    output paddr_t      paddr
);

    logic [7:0][7:0] w_mpr;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mpr
            mpr_t r_bank;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_bank <= 8'h00;
                end else if (mpr_we && mpr_sel[gi]) begin
                    r_bank <= mpr_wdata;
                end
            end

            assign w_mpr[gi] = r_bank;
        end
    endgenerate

    // Scan high to low so the lowest selected register wins.
    always_comb begin
        mpr_rdata = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (mpr_sel[i]) begin
                mpr_rdata = w_mpr[i];
            end
        end
    end

    assign paddr = {w_mpr[laddr[15:13]], laddr[12:0]};

endmodule

// File: rtl/huc6280_bus_if.sv
// HuC6280 CPU-side bus initiator.
//   clk, rst      : clock, asynchronous active-high reset
//   req, req_we   : core access request (sampled in IDLE) and direction
//   laddr, wdata  : logical address and write data, qualified by req
//   rdata, ack    : read result and one-cycle completion pulse
//   mpr_we, mpr_sel, mpr_wdata, mpr_rdata : TAM/TMA port to the MPR file
//   bus           : physical bus to the responder (master side)
// Every access takes IDLE -> STROBE -> CAPTURE -> IDLE; ack is high for the
// cycle after CAPTURE regardless of direction or decode.
module huc6280_bus_if
    import huc6280_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [15:0] laddr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    input  logic        mpr_we,
    input  logic [7:0]  mpr_sel,
    input  logic [7:0]  mpr_wdata,
    output logic [7:0]  mpr_rdata,
    huc6280_bus_if_if.master bus
);

    paddr_t     w_paddr;
    chip_sel_t  w_sel;

    bus_state_t r_state;
    paddr_t     r_addr;
    logic [7:0] r_mem_dout;
    logic       r_re;
    logic       r_we;
    logic       r_ce_n;
    logic       r_cer_n;
    logic       r_ce7_n;
    logic [7:0] r_rdata;
    logic       r_ack;
    logic       r_is_read;
    logic       r_selected;

    huc6280_mpr_file u_mpr_file (
        .clk       (clk),
        .rst       (rst),
        .mpr_we    (mpr_we),
        .mpr_sel   (mpr_sel),
        .mpr_wdata (mpr_wdata),
        .mpr_rdata (mpr_rdata),
        .laddr     (laddr),
        .paddr     (w_paddr)
    );

    assign w_sel = decode_bank(w_paddr[20:13]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_mem_dout <= 8'h00;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_ce_n     <= 1'b1;
            r_cer_n    <= 1'b1;
            r_ce7_n    <= 1'b1;
            r_rdata    <= 8'h00;
            r_ack      <= 1'b0;
            r_is_read  <= 1'b0;
            r_selected <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        // w_paddr reflects MPR contents before any TAM on
                        // this same edge, so a concurrent TAM only affects
                        // later requests.
                        r_addr     <= w_paddr;
                        r_mem_dout <= wdata;
                        r_is_read  <= ~req_we;
                        r_selected <= (w_sel != SEL_NONE);
                        r_re       <= ~req_we && (w_sel != SEL_NONE);
                        r_we       <= req_we && (w_sel != SEL_NONE);
                        r_ce_n     <= (w_sel != SEL_ROM);
                        r_cer_n    <= (w_sel != SEL_RAM);
                        r_ce7_n    <= (w_sel != SEL_IO);
                        r_state    <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    // Responder samples on this edge; addr is held.
                    r_re    <= 1'b0;
                    r_we    <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_cer_n <= 1'b1;
                    r_ce7_n <= 1'b1;
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (r_is_read) begin
                        r_rdata <= r_selected ? bus.mem_din : OPEN_BUS;
                    end
                    r_ack   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.addr     = r_addr;
    assign bus.mem_dout = r_mem_dout;
    assign bus.re       = r_re;
    assign bus.we       = r_we;
    assign bus.CE_n     = r_ce_n;
    assign bus.CER_n    = r_cer_n;
    assign bus.CE7_n    = r_ce7_n;
    assign rdata        = r_rdata;
    assign ack          = r_ack;

endmodule

// File: tb/tb_huc6280_bus_if.sv
module tb_huc6280_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [15:0] laddr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        mpr_we;
    logic [7:0]  mpr_sel;
    logic [7:0]  mpr_wdata;
    logic [7:0]  mpr_rdata;

    int total = 0;
    int bad   = 0;

    huc6280_bus_if_if bus ();

    huc6280_bus_if dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .laddr     (laddr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .mpr_we    (mpr_we),
        .mpr_sel   (mpr_sel),
        .mpr_wdata (mpr_wdata),
        .mpr_rdata (mpr_rdata),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    // Responder model: registered read data, valid for one cycle after the
    // strobe edge, zero otherwise.
    logic [7:0] ram [0:8191];

    function automatic logic [7:0] rom_val(input logic [20:0] a);
        return (a == 21'h0) ? 8'h4C : (a[7:0] ^ a[20:13]);
    endfunction

    always @(posedge clk) begin
        if (bus.re) begin
            if (!bus.CE_n)       bus.mem_din <= rom_val(bus.addr);
            else if (!bus.CER_n) bus.mem_din <= ram[bus.addr[12:0]];
            else if (!bus.CE7_n) bus.mem_din <= 8'h40;
            else                 bus.mem_din <= 8'hEE;
        end else begin
            bus.mem_din <= 8'h00;
        end
        if (bus.we && !bus.CER_n) ram[bus.addr[12:0]] <= bus.mem_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Results of the last access
    int          n_re, n_we, n_ce, n_cer, n_ce7, n_both, ack_cyc;
    logic [20:0] a_addr;
    logic [7:0]  a_rdata;
    logic        a_ack_after;

    // Call at a negedge; returns at a negedge.
    task automatic access(input logic w, input logic [15:0] la, input logic [7:0] wd,
                          input logic tam_now, input logic [7:0] tsel, input logic [7:0] tdat);
        req = 1'b1; req_we = w; laddr = la; wdata = wd;
        if (tam_now) begin
            mpr_we = 1'b1; mpr_sel = tsel; mpr_wdata = tdat;
        end
        n_re = 0; n_we = 0; n_ce = 0; n_cer = 0; n_ce7 = 0; n_both = 0; ack_cyc = 0;
        a_addr = '0; a_rdata = '0;
        for (int k = 1; k <= 6 && ack_cyc == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                mpr_we = 1'b0;
                a_addr = bus.addr;
            end
            n_re   += int'(bus.re);
            n_we   += int'(bus.we);
            n_both += int'(bus.re & bus.we);
            n_ce   += int'(!bus.CE_n);
            n_cer  += int'(!bus.CER_n);
            n_ce7  += int'(!bus.CE7_n);
            if (ack) begin
                ack_cyc = k;
                a_rdata = rdata;
                req = 1'b0;
            end
        end
        req = 1'b0;
        @(negedge clk);
        a_ack_after = ack;
        $display("access we=%0b laddr=%h addr=%h rdata=%h ack_cyc=%0d", w, la, a_addr, a_rdata, ack_cyc);
    endtask

    task automatic tam(input logic [7:0] sel, input logic [7:0] dat);
        mpr_we = 1'b1; mpr_sel = sel; mpr_wdata = dat;
        @(negedge clk);
        mpr_we = 1'b0;
        $display("tam sel=%h data=%h", sel, dat);
    endtask

    task automatic tma_chk(input string tag, input logic [7:0] sel, input logic [7:0] exp);
        mpr_sel = sel;
        #1;
        chk(tag, mpr_rdata, exp);
        $display("tma sel=%h rdata=%h", sel, mpr_rdata);
    endtask

    int n_ack_rst;

    initial begin
        rst = 1'b1; req = 0; req_we = 0; laddr = 0; wdata = 0;
        mpr_we = 0; mpr_sel = 0; mpr_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_re",   bus.re, 0);
        chk("rst_we",   bus.we, 0);
        chk("rst_sel",  {bus.CE_n, bus.CER_n, bus.CE7_n}, 3'b111);
        chk("rst_addr", bus.addr, 0);
        chk("rst_dout", bus.mem_dout, 0);
        chk("rst_out",  {rdata, ack}, 0);
        rst = 1'b0;
        @(negedge clk);

        // ROM read of the reset vector bank
        access(0, 16'hE000, 8'h00, 0, 8'h00, 8'h00);
        chk("rom_addr", a_addr, 21'h000000);
        chk("rom_re",   n_re, 1);
        chk("rom_ce",   n_ce, 1);
        chk("rom_other", n_cer + n_ce7 + n_we, 0);
        chk("rom_ack",  ack_cyc, 3);
        chk("rom_data", a_rdata, 8'h4C);
        chk("rom_ack1", a_ack_after, 0);

        // Work RAM write then read back through MPR1
        tam(8'h02, 8'hF8);
        access(1, 16'h2030, 8'hA5, 0, 8'h00, 8'h00);
        chk("ramw_addr", a_addr, 21'h1F0030);
        chk("ramw_cer",  n_cer, 1);
        chk("ramw_we",   n_we, 1);
        chk("ramw_re",   n_re, 0);
        chk("ramw_ack",  ack_cyc, 3);
        access(0, 16'h2030, 8'h00, 0, 8'h00, 8'h00);
        chk("ramr_data", a_rdata, 8'hA5);
        chk("ramr_both", n_both, 0);
        tma_chk("tma_02", 8'h02, 8'hF8);

        // IO page through MPR0
        tam(8'h01, 8'hFF);
        access(0, 16'h1000, 8'h00, 0, 8'h00, 8'h00);
        chk("io_addr", a_addr, 21'h1FF000);
        chk("io_ce7",  n_ce7, 1);
        chk("io_others", n_ce + n_cer, 0);
        chk("io_data", a_rdata, 8'h40);

        // Unselected bank
        tam(8'h08, 8'hFC);
        access(0, 16'h6000, 8'h00, 0, 8'h00, 8'h00);
        chk("open_addr", a_addr, 21'h1F8000);
        chk("open_strb", n_re + n_we, 0);
        chk("open_sel",  n_ce + n_cer + n_ce7, 0);
        chk("open_ack",  ack_cyc, 3);
        chk("open_data", a_rdata, 8'hFF);

        // TAM on the acceptance edge uses pre-write MPR2
        access(0, 16'h4000, 8'h00, 1, 8'h04, 8'h10);
        chk("conf_addr", a_addr, 21'h000000);
        access(0, 16'h4000, 8'h00, 0, 8'h00, 8'h00);
        chk("conf_addr2", a_addr, 21'h020000);
        chk("conf_data2", a_rdata, 8'h10);
        tma_chk("tma_06", 8'h06, 8'hF8);
        tma_chk("tma_00", 8'h00, 8'h00);
        tam(8'h00, 8'h77);
        tma_chk("tam_nop", 8'hFF, 8'hFF);

        // Reset in the middle of STROBE
        req = 1'b1; req_we = 1'b0; laddr = 16'hE000;
        @(negedge clk);
        chk("mid_re_pre", bus.re, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_re",   bus.re, 0);
        chk("mid_sel",  {bus.CE_n, bus.CER_n, bus.CE7_n}, 3'b111);
        chk("mid_addr", bus.addr, 0);
        req = 1'b0;
        n_ack_rst = 0;
        repeat (3) begin
            @(negedge clk);
            n_ack_rst += int'(ack);
        end
        rst = 1'b0;
        @(negedge clk);
        n_ack_rst += int'(ack);
        chk("mid_noack", n_ack_rst, 0);
        tma_chk("mid_mpr0", 8'h01, 8'h00);
        tma_chk("mid_mpr1", 8'h02, 8'h00);
        access(0, 16'hE000, 8'h00, 0, 8'h00, 8'h00);
        chk("post_addr", a_addr, 21'h000000);
        chk("post_ack",  ack_cyc, 3);
        chk("post_data", a_rdata, 8'h4C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/huc6280_bus_if.md
Name: huc6280_bus_if

Overview:
- CPU-side bus initiator for the HuC6280 physical bus: the requester end of the 21-bit addr/re/we/CE_n/CER_n interface that the memory/IO responder model answers.
- Accepts 16-bit logical accesses from the CPU core and translates them through the eight MPR bank registers (TAM/TMA).
- Generates physical address, strobes and chip selects, and captures the responder's registered read data.
- Returns one-cycle ack to the core.

Parameters:
- RAM_BANK_LO, 8'hF8, first bank decoded as work RAM (CER_n)
- RAM_BANK_HI, 8'hFB, last bank decoded as work RAM
- IO_BANK, 8'hFF, bank decoded as hardware IO page (CE7_n)
- OPEN_BUS, 8'hFF, read data returned for unselected banks

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  core access request, sampled in IDLE only
- req_we  in  1  1=write, 0=read; qualified by req
- laddr  in  16  logical address; qualified by req
- wdata  in  8  write data; qualified by req
- rdata  out  8  read result; valid while ack=1
- ack  out  1  one-cycle completion pulse
- mpr_we  in  1  TAM strobe
- mpr_sel  in  8  MPR select mask (bit n = MPRn)
- mpr_wdata  in  8  TAM data
- mpr_rdata  out  8  TMA result (combinational)
- addr  out  21  physical address to responder
- mem_dout  out  8  write data to responder dIn
- mem_din  in  8  read data from responder dOut (registered by responder, valid one cycle after strobe)
- re  out  1  read strobe
- we  out  1  write strobe
- CE_n  out  1  ROM/HuCard select, active low
- CER_n  out  1  work RAM select, active low
- CE7_n  out  1  IO page select, active low

Behaviour:
- Reset (async, immediate):
  - re=we=0; CE_n=CER_n=CE7_n=1; addr=0; mem_dout=0; rdata=0; ack=0.
  - All MPR0..7=8'h00, so bank 0 is mapped at $E000 for the reset vector.
  - State=IDLE.
  - Reset mid-access aborts it: no ack, no strobe survives.
- Translation: paddr = {MPR[laddr[15:13]], laddr[12:0]}. Translation and decode are latched at request acceptance.
- Decode on bank b = paddr[20:13]:
  - RAM_BANK_LO<=b<=RAM_BANK_HI -> CER_n
  - b==IO_BANK -> CE7_n
  - 8'h00..RAM_BANK_LO-1 -> CE_n
  - otherwise unselected: no strobe, no select
- FSM, all outputs registered:
  - IDLE: req=1 at edge E0 -> drive addr, mem_dout=wdata, re=~req_we, we=req_we, one select low (none if unselected); go to STROBE. ack forced 0.
  - STROBE (E0..E1): responder samples at E1. At E1: strobes/selects deassert, addr held; go to CAPTURE.
  - CAPTURE (E1..E2): at E2:
    - read: rdata<=mem_din; unselected read: rdata<=OPEN_BUS
    - write: rdata unchanged
    - ack<=1; go to IDLE
- Fixed latency: ack high during E2..E3 for both reads and writes, selected or not.
- req is sampled again at E3, so max throughput is one access per 3 clocks.
- req outside IDLE is ignored; the core must hold req until ack.
- re and we are never high together; exactly one or zero selects low, only in STROBE.
- TAM: on mpr_we, every MPRn with mpr_sel[n]=1 <= mpr_wdata; mask 0 is a no-op.
- mpr_we in the same cycle as request acceptance: the request uses pre-write MPR values, and the new values apply from the next request.
- mpr_we during STROBE/CAPTURE never alters the in-flight addr.
- TMA: mpr_rdata = MPR of the lowest set bit of mpr_sel; mask 0 -> 8'h00.

Decomposition:
- Shared package huc6280_pkg:
  - bus state enum (IDLE, STROBE, CAPTURE)
  - bank constants RAM_BANK_LO/HI, IO_BANK, OPEN_BUS
  - typedef mpr_t (8-bit bank)
  - typedef paddr_t (21-bit)
- One natural sub-module: huc6280_mpr_file, holding the 8x8 register file, TAM mask write, TMA priority read and the combinational translate laddr->paddr.
- The FSM and decode stay in the top.

Test Plan:
- Reset, then read laddr=16'hE000 with the ROM responder holding 8'h4C at 21'h000000 -> addr=21'h000000, CE_n=0 and re=1 for exactly 1 cycle, ack 3 cycles after req, rdata=8'h4C.
- TAM mask 8'h02 data 8'hF8; write 8'hA5 to laddr 16'h2030; read it back -> write: addr=21'h1F0030, CER_n=0, we=1. Read: rdata=8'hA5. TMA with mask 8'h02 -> 8'hF8.
- TAM mask 8'h01 data 8'hFF; read laddr 16'h1000 -> addr=21'h1FF000, CE7_n=0, rdata=8'h40 (region bits).
- TAM MPR3=8'hFC; read laddr 16'h6000 -> no strobe and no select for the whole access, ack at the same latency, rdata=8'hFF.
- Same-edge conflict: mpr_we (mask 8'h04, data 8'h10) in the cycle req reads 16'h4000 with MPR2=0 -> addr=21'h000000. The next read gives addr=21'h020000. mask 8'h06 TMA returns MPR1.
- Assert rst during STROBE -> re/we/selects drop asynchronously, no ack. After release, MPRs=0 and the next req completes normally.
